// File: rtl/cavlc_bitstream_pointer_pkg.sv
// Shared CAVLC decoder state codes and default widths for the bitstream pointer.
package cavlc_bitstream_pointer_pkg;

   localparam int DEFAULT_WORD_W    = 16;
   localparam int DEFAULT_WIN_W     = 16;
   localparam int DEFAULT_LEN_W     = 5;
   localparam int DEFAULT_BUF_WORDS = 4;

   // Any code outside this set selects a zero consumed length.
   typedef enum logic [3:0] {
      CAVLC_IDLE               = 4'd0,
      NumCoeffTrailingOnes_LUT = 4'd1,
      TrailingOnesSignFlag     = 4'd2,
      LevelPrefix              = 4'd3,
      LevelSuffix              = 4'd4,
      total_zeros_LUT          = 4'd5,
      run_before_LUT           = 4'd6
   } cavlc_state_t;

endpackage

// File: rtl/cavlc_window_extract.sv
// Circular barrel extractor: returns WIN_W bits starting at rd_ptr, wrapping
// from the last buffer bit back to bit 0. Stream bit 0 sits at buf_flat MSB.
module cavlc_window_extract #(
   parameter int BUF_BITS = 64,
   parameter int WIN_W    = 16,
   parameter int PTR_W    = 6
) (
   input  logic [BUF_BITS-1:0] buf_flat,
   input  logic [PTR_W-1:0]    rd_ptr,
   output logic [WIN_W-1:0]    window_out
);

   logic [PTR_W-1:0] idx;

   // With a power-of-2 buffer, ~idx equals BUF_BITS-1-idx and the add wraps for free.
   always_comb begin
      idx        = '0;
      window_out = '0;
      for (int j = 0; j < WIN_W; j++) begin
         idx                     = rd_ptr + PTR_W'(j);
         window_out[WIN_W-1-j]   = buf_flat[~idx];
      end
   end

endmodule

// File: rtl/cavlc_bitstream_pointer.sv
// Registered CAVLC bit pointer: selects the consumed length per decoder state,
// buffers bitstream words and exposes a look-ahead window.
// Optional byte alignment request is enabled by defining CAVLC_BYTE_ALIGN_EN.
module cavlc_bitstream_pointer
   import cavlc_bitstream_pointer_pkg::*;
#(
   parameter int WORD_W    = DEFAULT_WORD_W,
   parameter int BUF_WORDS = DEFAULT_BUF_WORDS,
   parameter int WIN_W     = DEFAULT_WIN_W,
   parameter int LEN_W     = DEFAULT_LEN_W
) (
   input  logic               clk,
   input  logic               reset_n,
`ifdef CAVLC_BYTE_ALIGN_EN
   input  logic               align_req,
`endif
   input  logic [3:0]         cavlc_decoder_state,
   input  logic               consume_valid,
   input  logic [LEN_W-1:0]   NumCoeffTrailingOnes_len,
   input  logic [1:0]         TrailingOnes,
   input  logic [LEN_W-2:0]   heading_one_pos,
   input  logic [LEN_W-2:0]   levelSuffixSize,
   input  logic [LEN_W-2:0]   total_zeros_len,
   input  logic [LEN_W-2:0]   run_of_zeros_len,
   input  logic [WORD_W-1:0]  word_in,
   input  logic               word_valid,
   output logic               word_ready,
   output logic [WIN_W-1:0]   window_out,
   output logic               window_valid,
   output logic               stall,
   output logic [LEN_W-1:0]   cavlc_consumed_bits_len
);

   localparam int BUF_BITS = WORD_W * BUF_WORDS;
   localparam int PTR_W    = $clog2(BUF_BITS);
   localparam int IDX_W    = $clog2(BUF_WORDS);
   localparam int AVAIL_W  = $clog2(BUF_BITS + 1);

   logic [WORD_W-1:0]   buffer [BUF_WORDS];
   logic [BUF_BITS-1:0] buf_flat;
   logic [PTR_W-1:0]    rd_ptr;
   logic [IDX_W-1:0]    wr_idx;
   logic [AVAIL_W-1:0]  bits_avail;

   logic [LEN_W-1:0]    sel_len;
   logic [LEN_W-1:0]    len;
   logic                req;
   logic                do_write;
   logic                do_consume;

   always_comb begin
      sel_len = '0;
      case (cavlc_decoder_state)
         NumCoeffTrailingOnes_LUT: sel_len = NumCoeffTrailingOnes_len;
         TrailingOnesSignFlag:     sel_len = LEN_W'(TrailingOnes);
         LevelPrefix:              sel_len = LEN_W'(heading_one_pos) + LEN_W'(1);
         LevelSuffix:              sel_len = LEN_W'(levelSuffixSize);
         total_zeros_LUT:          sel_len = LEN_W'(total_zeros_len);
         run_before_LUT:           sel_len = LEN_W'(run_of_zeros_len);
         default:                  sel_len = '0;
      endcase
   end

`ifdef CAVLC_BYTE_ALIGN_EN
   logic [2:0] align_len;
   assign align_len = 3'd0 - rd_ptr[2:0];

   // A real consume always takes priority over an alignment request.
   always_comb begin
      req = 1'b0;
      len = sel_len;
      if (consume_valid) begin
         req = 1'b1;
         len = sel_len;
      end else if (align_req) begin
         req = 1'b1;
         len = LEN_W'(align_len);
      end
   end
`else
   assign req = consume_valid;
   assign len = sel_len;
`endif

   assign cavlc_consumed_bits_len = len;

   // Stall compares against pre-write occupancy; a word arriving now cannot help.
   assign stall        = req && (AVAIL_W'(len) > bits_avail);
   assign word_ready   = bits_avail <= AVAIL_W'(BUF_BITS - WORD_W);
   assign window_valid = bits_avail >= AVAIL_W'(WIN_W);
   assign do_write     = word_valid && word_ready;
   assign do_consume   = req && !stall;

   for (genvar i = 0; i < BUF_WORDS; i++) begin : g_flat
      assign buf_flat[BUF_BITS-1-i*WORD_W -: WORD_W] = buffer[i];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr     <= '0;
         wr_idx     <= '0;
         bits_avail <= '0;
         for (int i = 0; i < BUF_WORDS; i++) begin
            buffer[i] <= '0;
         end
      end else begin
         if (do_write) begin
            buffer[wr_idx] <= word_in;
            wr_idx         <= wr_idx + IDX_W'(1);
         end
         if (do_consume) begin
            rd_ptr <= rd_ptr + PTR_W'(len);
         end
         bits_avail <= bits_avail
                       + (do_write   ? AVAIL_W'(WORD_W) : AVAIL_W'(0))
                       - (do_consume ? AVAIL_W'(len)    : AVAIL_W'(0));
      end
   end

   cavlc_window_extract #(
      .BUF_BITS (BUF_BITS),
      .WIN_W    (WIN_W),
      .PTR_W    (PTR_W)
   ) u_extract (
      .buf_flat   (buf_flat),
      .rd_ptr     (rd_ptr),
      .window_out (window_out)
   );

endmodule

// File: tb/tb_cavlc_bitstream_pointer.sv
// Table-driven bench for cavlc_bitstream_pointer with a bit-level reference model
// and a scoreboard of post-edge window/ready expectations.
module tb_cavlc_bitstream_pointer;
   import cavlc_bitstream_pointer_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
`ifdef CAVLC_BYTE_ALIGN_EN
   logic        align_req;
`endif
   logic [3:0]  cavlc_decoder_state;
   logic        consume_valid;
   logic [4:0]  NumCoeffTrailingOnes_len;
   logic [1:0]  TrailingOnes;
   logic [3:0]  heading_one_pos;
   logic [3:0]  levelSuffixSize;
   logic [3:0]  total_zeros_len;
   logic [3:0]  run_of_zeros_len;
   logic [15:0] word_in;
   logic        word_valid;
   logic        word_ready;
   logic [15:0] window_out;
   logic        window_valid;
   logic        stall;
   logic [4:0]  cavlc_consumed_bits_len;

   cavlc_bitstream_pointer dut (
      .clk                      (clk),
      .reset_n                  (reset_n),
`ifdef CAVLC_BYTE_ALIGN_EN
      .align_req                (align_req),
`endif
      .cavlc_decoder_state      (cavlc_decoder_state),
      .consume_valid            (consume_valid),
      .NumCoeffTrailingOnes_len (NumCoeffTrailingOnes_len),
      .TrailingOnes             (TrailingOnes),
      .heading_one_pos          (heading_one_pos),
      .levelSuffixSize          (levelSuffixSize),
      .total_zeros_len          (total_zeros_len),
      .run_of_zeros_len         (run_of_zeros_len),
      .word_in                  (word_in),
      .word_valid               (word_valid),
      .word_ready               (word_ready),
      .window_out               (window_out),
      .window_valid             (window_valid),
      .stall                    (stall),
      .cavlc_consumed_bits_len  (cavlc_consumed_bits_len)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  state;
      logic        cons;
      logic        align;
      logic [4:0]  nct;
      logic [1:0]  to;
      logic [3:0]  hop;
      logic [3:0]  lss;
      logic [3:0]  tz;
      logic [3:0]  rb;
      logic [15:0] word;
      logic        wv;
      logic [4:0]  exp_len;
      logic        exp_stall;
   } vec_t;

   typedef struct {
      logic [15:0] win;
      logic        wvalid;
      logic        wready;
   } exp_t;

   vec_t        tbl[$];
   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] m_buf [4];
   int          m_rd, m_wr, m_avail;

   function automatic vec_t mk(input logic [3:0] state, input logic cons, input logic align,
                               input logic [4:0] nct, input logic [1:0] to, input logic [3:0] hop,
                               input logic [3:0] lss, input logic [3:0] tz, input logic [3:0] rb,
                               input logic [15:0] word, input logic wv,
                               input logic [4:0] exp_len, input logic exp_stall);
      vec_t v;
      v.state = state; v.cons = cons; v.align = align; v.nct = nct; v.to = to;
      v.hop = hop; v.lss = lss; v.tz = tz; v.rb = rb; v.word = word; v.wv = wv;
      v.exp_len = exp_len; v.exp_stall = exp_stall;
      return v;
   endfunction

   function automatic logic [15:0] modelWindow();
      logic [15:0] w;
      int p;
      w = '0;
      for (int j = 0; j < 16; j++) begin
         p = (m_rd + j) % 64;
         w[15-j] = m_buf[p/16][15-(p%16)];
      end
      return w;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 4; i++) m_buf[i] = '0;
      m_rd = 0; m_wr = 0; m_avail = 0;
   endtask

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic checkOutput(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("[TB] FAIL %s scoreboard empty actual=0 required=1", name);
      end else begin
         e = sb.pop_front();
         checkVal({name, " window_valid"}, 32'(window_valid), 32'(e.wvalid));
         checkVal({name, " word_ready"},   32'(word_ready),   32'(e.wready));
         if (e.wvalid) checkVal({name, " window_out"}, 32'(window_out), 32'(e.win));
      end
   endtask

   // Drives one cycle, checks combinational outputs, advances the model, then checks post-edge state.
   task automatic applyStimulus(input vec_t v, input string name);
      exp_t e;
      logic wr_ok;
      logic cons_ok;
      cavlc_decoder_state      = v.state;
      consume_valid            = v.cons;
      NumCoeffTrailingOnes_len = v.nct;
      TrailingOnes             = v.to;
      heading_one_pos          = v.hop;
      levelSuffixSize          = v.lss;
      total_zeros_len          = v.tz;
      run_of_zeros_len         = v.rb;
      word_in                  = v.word;
      word_valid               = v.wv;
`ifdef CAVLC_BYTE_ALIGN_EN
      align_req                = v.align;
`endif
      #1;
      checkVal({name, " len"},   32'(cavlc_consumed_bits_len), 32'(v.exp_len));
      checkVal({name, " stall"}, 32'(stall),                   32'(v.exp_stall));
      wr_ok   = v.wv && (m_avail <= 48);
      cons_ok = (v.cons || v.align) && !v.exp_stall;
      if (cons_ok) begin
         m_rd    = (m_rd + int'(v.exp_len)) % 64;
         m_avail = m_avail - int'(v.exp_len);
      end
      if (wr_ok) begin
         m_buf[m_wr] = v.word;
         m_wr        = (m_wr + 1) % 4;
         m_avail     = m_avail + 16;
      end
      e.win    = modelWindow();
      e.wvalid = (m_avail >= 16);
      e.wready = (m_avail <= 48);
      sb.push_back(e);
      @(posedge clk);
      #1;
      checkOutput(name);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL timeout actual=running required=finished");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

   initial begin
      reset_n = 1'b0;
      cavlc_decoder_state = 4'd0; consume_valid = 1'b0; NumCoeffTrailingOnes_len = '0;
      TrailingOnes = '0; heading_one_pos = '0; levelSuffixSize = '0; total_zeros_len = '0;
      run_of_zeros_len = '0; word_in = '0; word_valid = 1'b0;
`ifdef CAVLC_BYTE_ALIGN_EN
      align_req = 1'b0;
`endif
      modelReset();

      //       state                     c  a  nct to hop lss tz rb  word      wv len st
      tbl.push_back(mk(CAVLC_IDLE,               1, 0, 0,  0, 0, 0,  0, 0, 16'hA5F0, 1, 0,  0));
      tbl.push_back(mk(CAVLC_IDLE,               0, 0, 0,  0, 0, 0,  0, 0, 16'h1234, 1, 0,  0));
      tbl.push_back(mk(LevelPrefix,              1, 0, 0,  0, 3, 0,  0, 0, 16'h0000, 0, 4,  0));
      tbl.push_back(mk(NumCoeffTrailingOnes_LUT, 1, 0, 10, 0, 0, 0,  0, 0, 16'h0000, 0, 10, 0));
      tbl.push_back(mk(run_before_LUT,           1, 0, 0,  0, 0, 0,  0, 7, 16'h0000, 0, 7,  0));
      tbl.push_back(mk(total_zeros_LUT,          1, 0, 0,  0, 0, 0,  9, 0, 16'h0000, 0, 9,  0));
      tbl.push_back(mk(TrailingOnesSignFlag,     1, 0, 0,  3, 0, 0,  0, 0, 16'h0000, 0, 3,  1));
      tbl.push_back(mk(TrailingOnesSignFlag,     1, 0, 0,  3, 0, 0,  0, 0, 16'hBEEF, 1, 3,  1));
      tbl.push_back(mk(TrailingOnesSignFlag,     1, 0, 0,  3, 0, 0,  0, 0, 16'h0000, 0, 3,  0));
      tbl.push_back(mk(LevelSuffix,              1, 0, 0,  0, 0, 15, 0, 0, 16'hC0DE, 1, 15, 0));
      tbl.push_back(mk(CAVLC_IDLE,               0, 0, 7,  2, 5, 5,  5, 5, 16'h1357, 1, 0,  0));
      tbl.push_back(mk(CAVLC_IDLE,               0, 0, 0,  0, 0, 0,  0, 0, 16'h2468, 1, 0,  0));
      tbl.push_back(mk(CAVLC_IDLE,               0, 0, 0,  0, 0, 0,  0, 0, 16'h9ABC, 1, 0,  0));
      tbl.push_back(mk(CAVLC_IDLE,               0, 0, 0,  0, 0, 0,  0, 0, 16'hFFFF, 1, 0,  0));
      tbl.push_back(mk(NumCoeffTrailingOnes_LUT, 1, 0, 16, 0, 0, 0,  0, 0, 16'h0000, 0, 16, 0));
      tbl.push_back(mk(total_zeros_LUT,          1, 0, 0,  0, 0, 0,  8, 0, 16'h0000, 0, 8,  0));
      tbl.push_back(mk(run_before_LUT,           1, 0, 0,  0, 0, 0,  0, 5, 16'h7777, 1, 5,  0));
      tbl.push_back(mk(NumCoeffTrailingOnes_LUT, 1, 0, 16, 0, 0, 0,  0, 0, 16'h0000, 0, 16, 0));
      tbl.push_back(mk(NumCoeffTrailingOnes_LUT, 1, 0, 16, 0, 0, 0,  0, 0, 16'h0000, 0, 16, 0));
      tbl.push_back(mk(NumCoeffTrailingOnes_LUT, 1, 0, 16, 0, 0, 0,  0, 0, 16'h0000, 0, 16, 0));
      tbl.push_back(mk(CAVLC_IDLE,               0, 0, 0,  0, 0, 0,  0, 0, 16'h4BCD, 1, 0,  0));
      tbl.push_back(mk(LevelPrefix,              1, 0, 0,  0, 15,0,  0, 0, 16'h0000, 0, 16, 0));
      tbl.push_back(mk(NumCoeffTrailingOnes_LUT, 1, 0, 16, 0, 0, 0,  0, 0, 16'h0000, 0, 16, 1));
      tbl.push_back(mk(4'd15,                    1, 0, 9,  3, 9, 9,  9, 9, 16'h0000, 0, 0,  0));

      repeat (2) @(posedge clk);
      #1;
      checkVal("reset word_ready",   32'(word_ready),   32'd1);
      checkVal("reset window_valid", 32'(window_valid), 32'd0);
      reset_n = 1'b1;
      #1;

      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i], $sformatf("vec%0d", i));
      end

      // Mid-stream reset must drop all buffered bits.
      cavlc_decoder_state = NumCoeffTrailingOnes_LUT;
      NumCoeffTrailingOnes_len = 5'd5;
      consume_valid = 1'b1;
      word_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      checkVal("midreset word_ready",   32'(word_ready),   32'd1);
      checkVal("midreset window_valid", 32'(window_valid), 32'd0);
      checkVal("midreset stall",        32'(stall),        32'd1);
      @(posedge clk);
      #1;
      checkVal("midreset hold stall",   32'(stall),        32'd1);
      reset_n = 1'b1;
      modelReset();
      applyStimulus(mk(CAVLC_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0F0F, 1, 0, 0), "postreset write");

`ifdef CAVLC_BYTE_ALIGN_EN
      applyStimulus(mk(CAVLC_IDLE,               0, 0, 0, 0, 0, 0,  0, 0, 16'hAAAA, 1, 0,  0), "align fill");
      applyStimulus(mk(LevelSuffix,              1, 0, 0, 0, 0, 13, 0, 0, 16'h0000, 0, 13, 0), "align to13");
      applyStimulus(mk(CAVLC_IDLE,               0, 1, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 3,  0), "align from13");
      applyStimulus(mk(CAVLC_IDLE,               0, 1, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 0,  0), "align from16");
      applyStimulus(mk(NumCoeffTrailingOnes_LUT, 1, 1, 2, 0, 0, 0,  0, 0, 16'h0000, 0, 2,  0), "align vs consume");
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cavlc_bitstream_pointer.md
Name: cavlc_bitstream_pointer

Overview:
- Registered successor to the combinational CAVLC consumed-length mux.
- Selects the consumed-bit length for the current CAVLC decoder state and maintains a circular bit buffer of incoming bitstream words.
- Advances the read pointer by that length each cycle, and presents a WIN_W-bit look-ahead window to the CAVLC LUT stages.
- Sits between the bitstream word fetcher (valid/ready) and the CAVLC decoder FSM; stalls the FSM when too few bits are buffered.

Parameters:
- WORD_W, 16, width of each incoming bitstream word.
- BUF_WORDS, 4, buffer depth in words; must be a power of 2 and at least 2. BUF_BITS = WORD_W*BUF_WORDS.
- WIN_W, 16, look-ahead window width; must be ≤ BUF_BITS-WORD_W.
- LEN_W, 5, width of the consumed-length datapath; lengths are 0..WIN_W.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cavlc_decoder_state  in  4  current CAVLC decoder state (shared state codes)
- consume_valid  in  1  FSM consumes selected length this cycle
- NumCoeffTrailingOnes_len  in  LEN_W  coeff_token code length
- TrailingOnes  in  2  number of trailing-one sign bits
- heading_one_pos  in  LEN_W-1  level_prefix leading-zero count
- levelSuffixSize  in  LEN_W-1  level_suffix size
- total_zeros_len  in  LEN_W-1  total_zeros code length
- run_of_zeros_len  in  LEN_W-1  run_before code length
- word_in  in  WORD_W  bitstream word, MSB first
- word_valid  in  1  word_in valid
- word_ready  out  1  buffer can accept a word
- window_out  out  WIN_W  next WIN_W bits from the read pointer, MSB = next bit
- window_valid  out  1  bits_avail ≥ WIN_W
- stall  out  1  consume request cannot be honoured this cycle
- cavlc_consumed_bits_len  out  LEN_W  selected length (combinational)

Behaviour:
- Length select (combinational):
  - NumCoeffTrailingOnes_LUT → NumCoeffTrailingOnes_len.
  - TrailingOnesSignFlag → TrailingOnes, zero-extended.
  - LevelPrefix → heading_one_pos+1, LEN_W wide, no overflow because heading_one_pos ≤ 15.
  - LevelSuffix, total_zeros_LUT, run_before_LUT → the respective length, zero-extended.
  - Any other state → 0.
- Registers:
  - rd_ptr: clog2(BUF_BITS) bits, wraps modulo BUF_BITS.
  - wr_idx: clog2(BUF_WORDS) bits.
  - bits_avail: 0..BUF_BITS.
  - buffer storage: BUF_WORDS×WORD_W.
- Reset values: rd_ptr=0, wr_idx=0, bits_avail=0, buffer=0.
  - Resulting outputs: word_ready=1, window_valid=0, stall=consume_valid&&(len>0).
  - Reset mid-stream discards all buffered bits.
- word_ready = (bits_avail ≤ BUF_BITS-WORD_W), derived from registers only.
- Word write: on word_valid&&word_ready, buffer[wr_idx] ← word_in, wr_idx+1 (wrap), bits_avail += WORD_W.
- stall = consume_valid && (len > bits_avail), where len is the selected length.
- Consume: on consume_valid&&!stall, rd_ptr += len (mod BUF_BITS) and bits_avail -= len.
  - A len of 0 is a no-op and never stalls.
- Simultaneous write and consume in one cycle: bits_avail ← bits_avail + WORD_W − len.
  - The check uses pre-write bits_avail; an incoming word never satisfies a same-cycle consume.
- window_out is combinational from the buffer and rd_ptr.
  - Bits beyond bits_avail are don't-care; consumers gate on window_valid.
  - Reads wrap across the buffer end (bit BUF_BITS-1 followed by bit 0).
- Latency: a written word is visible in window_out the next cycle. A consume moves the window the next cycle.
- Full buffer: word_ready=0 and word_valid is ignored. Empty buffer: any nonzero consume stalls.

Optional Feature:
- CAVLC_BYTE_ALIGN_EN defined:
  - Adds input align_req (1 bit).
  - When align_req is high and consume_valid is low, the consumed length is (8 − rd_ptr[2:0]) mod 8, subject to the same stall rule.
  - Used for RBSP trailing-bit/byte alignment.
  - align_req together with consume_valid: consume_valid wins.
- Undefined: the port is absent; no alignment logic.

Decomposition:
- Shared package/define file holds:
  - CAVLC state codes (NumCoeffTrailingOnes_LUT, TrailingOnesSignFlag, LevelPrefix, LevelSuffix, total_zeros_LUT, run_before_LUT).
  - Default WORD_W/WIN_W constants.
- One natural sub-module: cavlc_window_extract, the circular barrel extractor (buffer flat vector + rd_ptr → window_out).

Test Plan:
- Reset, then write 0xA5F0 and 0x1234 with no consume → bits_avail=32, window_valid=1, window_out=0xA5F0, word_ready=1.
- state=LevelPrefix, heading_one_pos=3, consume → len=4, next window_out=0x5F01, bits_avail=28.
- state=TrailingOnesSignFlag, TrailingOnes=3, bits_avail=2 → stall=1, rd_ptr unchanged; write a word → next cycle no stall, consume of 3 succeeds.
- Fill to bits_avail=64 → word_ready=0, word_valid ignored; consume 16 → word_ready=1 next cycle.
- Same-cycle write 16 and consume 5 with bits_avail=40 → bits_avail=51. Run rd_ptr across 63→0 and check window continuity.
- With CAVLC_BYTE_ALIGN_EN: rd_ptr=13, align_req=1 → consumes 3 bits, rd_ptr=16. With rd_ptr=16 → consumes 0 bits.
